// File: rtl/cube_root_seq_if.sv
// -----------------------------------------------------------------------------
// cube_root_seq_if
// Request/result bundle for the sequential floor cube-root block.
//   start  : request (master -> slave), sampled only while the block is idle
//   X      : radicand, W bits (master -> slave), latched when start is accepted
//   busy   : high while the block iterates (slave -> master)
//   done   : one-cycle pulse, results valid from this cycle (slave -> master)
//   R      : floor cube root, RW bits (slave -> master)
//   REM    : X - R^3, W bits (slave -> master)
//   exact  : 1 when REM == 0 (slave -> master)
// -----------------------------------------------------------------------------
interface cube_root_seq_if #(
  parameter int W  = 8,
  parameter int RW = 4
);
  logic          start;
  logic [W-1:0]  X;
  logic          busy;
  logic          done;
  logic [RW-1:0] R;
  logic [W-1:0]  REM;
  logic          exact;

  modport master (output start, X, input busy, done, R, REM, exact);
  modport slave  (input start, X, output busy, done, R, REM, exact);
endinterface

// File: rtl/cube_root_seq.sv
// -----------------------------------------------------------------------------
// cube_root_seq
// Iterative floor cube root. Candidate r steps up by one per clock while
// (r+1)^3 <= X. The cube and square of r are tracked incrementally, so no
// multiplier is needed:
//   (r+1)^3 = r^3 + 3r^2 + 3r + 1
//   (r+1)^2 = r^2 + 2r + 1
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : cube_root_seq_if.slave (start/X in, busy/done/R/REM/exact out)
// Latency from the accepting edge to done is R+1 clocks.
// -----------------------------------------------------------------------------
module cube_root_seq #(
  parameter int W  = 8,
  parameter int RW = 4
) (
  input  logic           clk,
  input  logic           rst,
  cube_root_seq_if.slave bus
);
  // Cube and square of the candidate must never overflow.
  localparam int CW = 3 * RW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  xl_q,    xl_d;
  logic [RW-1:0] r_q,     r_d;
  logic [CW-1:0] cube_q,  cube_d;
  logic [CW-1:0] sq_q,    sq_d;
  logic [RW-1:0] root_q,  root_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic          exact_q, exact_d;
  logic          done_q,  done_d;
  logic          busy_s;

  logic [CW-1:0] r_ext_s;
  logic [CW-1:0] xl_ext_s;
  logic [CW-1:0] nc_s;
  logic          over_s;

  // Next candidate cube (r+1)^3 and the stop test against the zero-extended operand.
  always_comb begin
    r_ext_s  = CW'(r_q);
    xl_ext_s = CW'(xl_q);
    nc_s     = cube_q + (sq_q << 1) + sq_q + (r_ext_s << 1) + r_ext_s + CW'(1);
    over_s   = (nc_s > xl_ext_s);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xl_q    <= '0;
      r_q     <= '0;
      cube_q  <= '0;
      sq_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      exact_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xl_q    <= xl_d;
      r_q     <= r_d;
      cube_q  <= cube_d;
      sq_q    <= sq_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CALC;
        else           state_d = IDLE;
      end
      CALC: begin
        if (over_s) state_d = IDLE;
        else        state_d = CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result next values; results hold until the next completion.
  always_comb begin
    xl_d    = xl_q;
    r_d     = r_q;
    cube_d  = cube_q;
    sq_d    = sq_q;
    root_d  = root_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          xl_d   = bus.X;
          r_d    = '0;
          cube_d = '0;
          sq_d   = '0;
        end else begin
          xl_d = xl_q;
        end
      end
      CALC: begin
        if (over_s) begin
          root_d  = r_q;
          // Modular W-bit subtraction equals the truncated full-width difference.
          rem_d   = xl_q - cube_q[W-1:0];
          exact_d = (xl_ext_s == cube_q);
          done_d  = 1'b1;
        end else begin
          r_d    = r_q + RW'(1);
          cube_d = nc_s;
          sq_d   = sq_q + (r_ext_s << 1) + CW'(1);
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Output decode of the state register.
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      IDLE:    busy_s = 1'b0;
      CALC:    busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  assign bus.busy  = busy_s;
  assign bus.done  = done_q;
  assign bus.R     = root_q;
  assign bus.REM   = rem_q;
  assign bus.exact = exact_q;

endmodule

// File: tb/tb_cube_root_seq.sv
// -----------------------------------------------------------------------------
// tb_cube_root_seq
// Self-checking bench for cube_root_seq: directed cases, a back-to-back sweep
// of every 8-bit input, random operands, ignored start while busy and reset
// abort. Expected results come from a plain-arithmetic floor cube root.
// -----------------------------------------------------------------------------
module tb_cube_root_seq;
  localparam int W  = 8;
  localparam int RW = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cube_root_seq_if #(.W(W), .RW(RW)) bus ();

  cube_root_seq #(.W(W), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cbrt_floor(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: drive the request, let one edge accept it, drop start.
  task automatic start_op(input int x);
    bus.start = 1'b1;
    bus.X     = W'(x);
    cyc();
    bus.start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; returns edges until done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      cyc();
      lat++;
    end
    check("done_seen", bus.done, 1);
  endtask

  task automatic check_result(input string tag, input int x, input int lat);
    int r;
    int rem;
    r   = cbrt_floor(x);
    rem = x - r * r * r;
    check({tag, "_R"},     bus.R,     r);
    check({tag, "_REM"},   bus.REM,   rem);
    check({tag, "_exact"}, bus.exact, (rem == 0) ? 1 : 0);
    check({tag, "_lat"},   lat,       r + 1);
    check({tag, "_busy"},  bus.busy,  0);
  endtask

  initial begin
    int lat;
    int bc;
    int x;
    int dones;
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.X     = '0;

    // Reset held for two cycles, then idle with start low.
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rst_busy",  bus.busy,  0);
      check("rst_done",  bus.done,  0);
      check("rst_R",     bus.R,     0);
      check("rst_REM",   bus.REM,   0);
      check("rst_exact", bus.exact, 0);
    end

    // Exact cube 27: four busy cycles, R=3, REM=0, exact=1.
    start_op(27);
    wait_done(lat, bc);
    check("c27_R",     bus.R,     3);
    check("c27_REM",   bus.REM,   0);
    check("c27_exact", bus.exact, 1);
    check("c27_lat",   lat,       4);
    check("c27_busyc", bc,        4);
    cyc();
    check("c27_pulse", bus.done,  0);
    check("c27_hold",  bus.R,     3);

    // Non-cube and boundary operands.
    start_op(26);
    wait_done(lat, bc);
    check("c26_R",     bus.R,     2);
    check("c26_REM",   bus.REM,   18);
    check("c26_exact", bus.exact, 0);
    cyc();
    start_op(0);
    wait_done(lat, bc);
    check("c0_R",      bus.R,     0);
    check("c0_REM",    bus.REM,   0);
    check("c0_exact",  bus.exact, 1);
    check("c0_lat",    lat,       1);
    cyc();
    start_op(255);
    wait_done(lat, bc);
    check("c255_R",     bus.R,     6);
    check("c255_REM",   bus.REM,   39);
    check("c255_exact", bus.exact, 0);
    check("c255_lat",   lat,       7);
    cyc();

    // Back-to-back sweep of every operand, restarting in each done cycle.
    start_op(0);
    for (int v = 0; v < 256; v++) begin
      wait_done(lat, bc);
      check_result("sweep", v, lat);
      if (v < 255) begin
        start_op(v + 1);
        check("sweep_nogap", bus.busy, 1);
      end
    end
    cyc();

    // Random operands against the model.
    for (int i = 0; i < 24; i++) begin
      x = int'($urandom_range(0, 255));
      start_op(x);
      wait_done(lat, bc);
      check_result("rand", x, lat);
      cyc();
    end

    // start and X toggled while busy must be ignored and not queued.
    start_op(125);
    bus.start = 1'b1;
    bus.X     = 8'd8;
    cyc();
    cyc();
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("ign_R",     bus.R,     5);
    check("ign_REM",   bus.REM,   0);
    check("ign_exact", bus.exact, 1);
    check("ign_lat",   lat,       4);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.done) dones++;
    end
    check("ign_nodone", dones, 0);
    check("ign_idle",   bus.busy, 0);

    // Reset mid-operation aborts without a done pulse.
    start_op(200);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy",  bus.busy,  0);
    check("abort_done",  bus.done,  0);
    check("abort_R",     bus.R,     0);
    check("abort_REM",   bus.REM,   0);
    check("abort_exact", bus.exact, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.done) dones++;
    end
    check("abort_nodone", dones, 0);
    start_op(64);
    wait_done(lat, bc);
    check("c64_R",     bus.R,     4);
    check("c64_REM",   bus.REM,   0);
    check("c64_exact", bus.exact, 1);
    check("c64_lat",   lat,       5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cube_root_seq.md
Name: cube_root_seq

Overview:
- Sequential inverse of the team's cube-operation block: given an unsigned value X, computes the integer floor cube root R.
- Also computes remainder REM = X - R^3 and an exact-cube flag.
- Used wherever a cubed result must be decoded back to its operand.
- Iterative and incremental: one candidate per clock, no multipliers, start/done handshake.

Parameters:
- W, 8, width of input X and of remainder REM.
- RW, 4, width of root R. Constraint: (2^RW - 1)^3 >= 2^W - 1. The defaults satisfy this.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- X  input  W  radicand; latched on the edge that accepts start.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse; R/REM/exact valid from this cycle.
- R  output  RW  floor(cbrt(X)).
- REM  output  W  X - R^3.
- exact  output  1  1 when REM == 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; busy=0, done=0, R=0, REM=0, exact=0; internal registers cleared. Reset mid-CALC aborts; no done pulse is produced.
- Internal registers:
  - Xl (W bits): latched operand.
  - r (RW bits): candidate root.
  - cube, sq (3*RW bits each): hold r^3 and r^2 with no overflow.
- States:
  - IDLE:
    - start=1 at an edge: Xl<=X, r<=0, cube<=0, sq<=0, go to CALC.
    - start=0: stay in IDLE.
  - CALC, once per edge:
    - nc = cube + 3*sq + 3*r + 1, i.e. (r+1)^3, computed at 3*RW width.
    - If nc > Xl: R<=r, REM<=Xl - cube (truncated to W), exact<=(Xl==cube), done<=1, go to IDLE.
    - Else: r<=r+1, cube<=nc, sq<=sq + 2*r + 1, stay in CALC.
- done is 0 in every cycle except the single cycle after the completing edge.
- busy = (state==CALC).
- Latency:
  - The edge accepting start is edge k; done is high after edge k+R+1.
  - Latency is R+1 clocks: X=0 gives 1 clock, X=255 gives 7 clocks at the defaults.
- R, REM and exact hold their values until the next completion or reset.
- start while busy is ignored; X changes during CALC have no effect.
- Back-to-back operation: start asserted during the done cycle (state already IDLE) is accepted at the next edge, giving zero idle gap.
- All arithmetic is unsigned. The comparison nc > Xl zero-extends Xl to 3*RW bits.
- Termination is guaranteed by the RW constraint: r never wraps.

Test Plan:
- Reset/idle: rst held 2 cycles, then released with start=0 → busy=0, done=0, R=0, REM=0, exact=0 indefinitely.
- Exact cube: X=27, start 1 cycle → busy for 4 cycles, done pulse after 4 edges, R=3, REM=0, exact=1.
- Non-cube and bounds:
  - X=26 → R=2, REM=18, exact=0.
  - X=0 → R=0, REM=0, exact=1, latency 1.
  - X=255 → R=6, REM=39, exact=0, latency 7.
- Sweep: X=0..255 back-to-back, start asserted in each done cycle → each result matches the floor cube root model; no idle cycles between operations.
- Ignored start / X glitch: X=125 started, then start=1 and X=8 driven during CALC → single done, R=5, REM=0, exact=1; the second request is not queued.
- Reset mid-operation: X=200 started, rst pulsed after 2 cycles → state IDLE, outputs 0, no done pulse. A new start with X=64 then gives R=4, exact=1.
